// File: rtl/control_pkg.sv
// Shared constants for the multicycle accumulator control FSM:
// state encodings, opcodes, result-mux selects and ALU operations.
// Optional feature macro used by importers: CONTROL_FSM_STALL_EN.
package control_pkg;

    localparam int OP_W  = 5;
    localparam int SEL_W = 5;

    // Codes 6 and 7 are never entered; the FSM recovers to FETCH from them.
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [OP_W-1:0] OP_ADD   = 5'd0;
    localparam logic [OP_W-1:0] OP_SUB   = 5'd1;
    localparam logic [OP_W-1:0] OP_AND   = 5'd2;
    localparam logic [OP_W-1:0] OP_OR    = 5'd3;
    localparam logic [OP_W-1:0] OP_LOAD  = 5'd4;
    localparam logic [OP_W-1:0] OP_LOADI = 5'd5;
    localparam logic [OP_W-1:0] OP_STORE = 5'd6;
    localparam logic [OP_W-1:0] OP_BEQZ  = 5'd7;
    localparam logic [OP_W-1:0] OP_JUMP  = 5'd8;
    localparam logic [OP_W-1:0] OP_HALT  = 5'd31;

    localparam logic [SEL_W-1:0] SEL_ALU  = 5'd0;
    localparam logic [SEL_W-1:0] SEL_MEM  = 5'd1;
    localparam logic [SEL_W-1:0] SEL_IMM  = 5'd2;
    localparam logic [SEL_W-1:0] SEL_ZERO = 5'd10;

    // ALU register-register ops occupy the lowest four opcodes, so the
    // ALU operation is simply the low two opcode bits.
    function automatic logic is_alu_op(input logic [OP_W-1:0] op);
        return (op <= OP_OR);
    endfunction

    function automatic logic is_defined_op(input logic [OP_W-1:0] op);
        return (op <= OP_JUMP) || (op == OP_HALT);
    endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational output map for the control FSM: (state, opcode, zero)
// to datapath strobes, mux select and ALU operation.
// With CONTROL_FSM_STALL_EN defined, FETCH only commits PC/IR writes in
// the cycle memory reports ready.
import control_pkg::*;

module control_decode #(
    parameter int OPW  = OP_W,
    parameter int SELW = SEL_W
) (
    input  logic [2:0]      i_state,
    input  logic [OPW-1:0]  i_opcode,
    input  logic            i_zero,
`ifdef CONTROL_FSM_STALL_EN
    input  logic            i_mem_ready,
`endif
    output logic            o_pc_write,
    output logic            o_pc_src,
    output logic            o_ir_write,
    output logic            o_mem_read,
    output logic            o_mem_write,
    output logic            o_acc_write,
    output logic [SELW-1:0] o_mux_sel,
    output logic [1:0]      o_alu_op,
    output logic            o_halted,
    output logic            o_illegal_op
);

    logic w_mem_ok;

`ifdef CONTROL_FSM_STALL_EN
    assign w_mem_ok = i_mem_ready;
`else
    assign w_mem_ok = 1'b1;
`endif

    // Per-state strobe generation; everything idles at 0 and the mux
    // select idles on the constant-zero input.
    always_comb begin
        o_pc_write   = 1'b0;
        o_pc_src     = 1'b0;
        o_ir_write   = 1'b0;
        o_mem_read   = 1'b0;
        o_mem_write  = 1'b0;
        o_acc_write  = 1'b0;
        o_mux_sel    = SEL_ZERO;
        o_alu_op     = 2'b00;
        o_halted     = 1'b0;
        o_illegal_op = 1'b0;
        case (i_state)
            S_FETCH: begin
                o_mem_read = 1'b1;
                o_ir_write = w_mem_ok;
                o_pc_write = w_mem_ok;
            end
            S_DECODE: begin
                if (i_opcode == OP_JUMP) begin
                    o_pc_src   = 1'b1;
                    o_pc_write = 1'b1;
                end else if (!is_defined_op(i_opcode)) begin
                    o_illegal_op = 1'b1;
                end
            end
            S_EXEC: begin
                if (i_opcode == OP_BEQZ) begin
                    o_pc_src   = 1'b1;
                    o_pc_write = i_zero;
                end else begin
                    o_alu_op = i_opcode[1:0];
                end
            end
            S_MEM: begin
                if (i_opcode == OP_LOAD) begin
                    o_mem_read = 1'b1;
                end else if (i_opcode == OP_STORE) begin
                    o_mem_write = 1'b1;
                end
            end
            S_WB: begin
                o_acc_write = 1'b1;
                if (i_opcode == OP_LOAD) begin
                    o_mux_sel = SEL_MEM;
                end else if (i_opcode == OP_LOADI) begin
                    o_mux_sel = SEL_IMM;
                end else begin
                    o_mux_sel = SEL_ALU;
                    o_alu_op  = i_opcode[1:0];
                end
            end
            S_HALT: begin
                o_halted = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/control_fsm.sv
// Multicycle control FSM for the accumulator datapath. Holds the state
// register and next-state logic; output decoding lives in control_decode.
// Reset masks every output combinationally, so strobes drop in the same
// cycle Reset rises.
// Optional feature: CONTROL_FSM_STALL_EN adds MemReady, which stretches
// FETCH and MEM until memory completes.
import control_pkg::*;

module control_fsm #(
    parameter int OPW  = OP_W,
    parameter int SELW = SEL_W
) (
    input  logic            CLK,
    input  logic            Reset,
    input  logic [OPW-1:0]  Opcode,
    input  logic            Zero,
`ifdef CONTROL_FSM_STALL_EN
    input  logic            MemReady,
`endif
    output logic            PCWrite,
    output logic            PCSrc,
    output logic            IRWrite,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            AccWrite,
    output logic [SELW-1:0] MuxSel,
    output logic [1:0]      ALUOp,
    output logic            Halted,
    output logic            IllegalOp,
    output logic [2:0]      State
);

    state_t r_state;
    state_t w_next_state;
    logic   w_mem_ok;

    logic            w_pc_write;
    logic            w_pc_src;
    logic            w_ir_write;
    logic            w_mem_read;
    logic            w_mem_write;
    logic            w_acc_write;
    logic [SELW-1:0] w_mux_sel;
    logic [1:0]      w_alu_op;
    logic            w_halted;
    logic            w_illegal_op;

`ifdef CONTROL_FSM_STALL_EN
    assign w_mem_ok = MemReady;
`else
    assign w_mem_ok = 1'b1;
`endif

    // State register with synchronous reset back to FETCH.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state sequencing; Opcode is already stable once DECODE is reached.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_FETCH: begin
                if (w_mem_ok) w_next_state = S_DECODE;
            end
            S_DECODE: begin
                if (is_alu_op(Opcode) || Opcode == OP_BEQZ) begin
                    w_next_state = S_EXEC;
                end else if (Opcode == OP_LOAD || Opcode == OP_STORE) begin
                    w_next_state = S_MEM;
                end else if (Opcode == OP_LOADI) begin
                    w_next_state = S_WB;
                end else if (Opcode == OP_HALT) begin
                    w_next_state = S_HALT;
                end else begin
                    w_next_state = S_FETCH;
                end
            end
            S_EXEC: begin
                w_next_state = (Opcode == OP_BEQZ) ? S_FETCH : S_WB;
            end
            S_MEM: begin
                if (w_mem_ok) begin
                    w_next_state = (Opcode == OP_LOAD) ? S_WB : S_FETCH;
                end
            end
            S_WB:    w_next_state = S_FETCH;
            S_HALT:  w_next_state = S_HALT;
            default: w_next_state = S_FETCH;
        endcase
    end

    control_decode #(
        .OPW  (OPW),
        .SELW (SELW)
    ) u_decode (
        .i_state      (r_state),
        .i_opcode     (Opcode),
        .i_zero       (Zero),
`ifdef CONTROL_FSM_STALL_EN
        .i_mem_ready  (MemReady),
`endif
        .o_pc_write   (w_pc_write),
        .o_pc_src     (w_pc_src),
        .o_ir_write   (w_ir_write),
        .o_mem_read   (w_mem_read),
        .o_mem_write  (w_mem_write),
        .o_acc_write  (w_acc_write),
        .o_mux_sel    (w_mux_sel),
        .o_alu_op     (w_alu_op),
        .o_halted     (w_halted),
        .o_illegal_op (w_illegal_op)
    );

    assign PCWrite   = w_pc_write   & ~Reset;
    assign PCSrc     = w_pc_src     & ~Reset;
    assign IRWrite   = w_ir_write   & ~Reset;
    assign MemRead   = w_mem_read   & ~Reset;
    assign MemWrite  = w_mem_write  & ~Reset;
    assign AccWrite  = w_acc_write  & ~Reset;
    assign MuxSel    = Reset ? SEL_ZERO : w_mux_sel;
    assign ALUOp     = Reset ? 2'b00 : w_alu_op;
    assign Halted    = w_halted     & ~Reset;
    assign IllegalOp = w_illegal_op & ~Reset;
    assign State     = Reset ? 3'd0 : r_state;

endmodule

// File: tb/tb_control_fsm.sv
// Bench for control_fsm: instruction-level reference model pushes one
// expected output vector per cycle; a monitor pops and compares.
// Vector layout: {State, PCWrite, PCSrc, IRWrite, MemRead, MemWrite,
// AccWrite, MuxSel, ALUOp, Halted, IllegalOp}.
module tb_control_fsm;

`ifdef CONTROL_FSM_STALL_EN
  localparam bit STALL = 1'b1;
`else
  localparam bit STALL = 1'b0;
`endif

  localparam int PH_F = 0;
  localparam int PH_D = 1;
  localparam int PH_E = 2;
  localparam int PH_M = 3;
  localparam int PH_W = 4;
  localparam int PH_H = 5;

  // clock / reset block
  logic CLK = 1'b0;
  logic Reset = 1'b1;
  logic [4:0] Opcode = 5'd0;
  logic Zero = 1'b0;
  logic MemReady = 1'b1;
  logic PCWrite, PCSrc, IRWrite, MemRead, MemWrite, AccWrite;
  logic [4:0] MuxSel;
  logic [1:0] ALUOp;
  logic Halted, IllegalOp;
  logic [2:0] State;

  always #5 CLK = ~CLK;

  control_fsm #(.OPW(5), .SELW(5)) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .Opcode    (Opcode),
    .Zero      (Zero),
`ifdef CONTROL_FSM_STALL_EN
    .MemReady  (MemReady),
`endif
    .PCWrite   (PCWrite),
    .PCSrc     (PCSrc),
    .IRWrite   (IRWrite),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .AccWrite  (AccWrite),
    .MuxSel    (MuxSel),
    .ALUOp     (ALUOp),
    .Halted    (Halted),
    .IllegalOp (IllegalOp),
    .State     (State)
  );

  logic [17:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  logic [17:0] act_vec;
  assign act_vec = {State, PCWrite, PCSrc, IRWrite, MemRead, MemWrite,
                    AccWrite, MuxSel, ALUOp, Halted, IllegalOp};

  function automatic logic [17:0] mk(input logic [2:0] st, input logic pcw,
      input logic pcs, input logic irw, input logic mrd, input logic mwr,
      input logic aw, input logic [4:0] sel, input logic [1:0] alu,
      input logic h, input logic il);
    return {st, pcw, pcs, irw, mrd, mwr, aw, sel, alu, h, il};
  endfunction

  function automatic logic [17:0] rst_vec();
    return mk(3'd0, 0, 0, 0, 0, 0, 0, 5'd10, 2'd0, 0, 0);
  endfunction

  // Reference: what the datapath should see in one cycle of a given phase.
  function automatic logic [17:0] phase_exp(input int ph, input logic [4:0] op,
                                            input logic z, input logic mr);
    logic [1:0] lo;
    logic [4:0] sel;
    lo = op[1:0];
    case (ph)
      PH_F: return mk(3'd0, mr, 0, mr, 1, 0, 0, 5'd10, 2'd0, 0, 0);
      PH_D: begin
        if (op == 5'd8) return mk(3'd1, 1, 1, 0, 0, 0, 0, 5'd10, 2'd0, 0, 0);
        if (op > 5'd8 && op < 5'd31) return mk(3'd1, 0, 0, 0, 0, 0, 0, 5'd10, 2'd0, 0, 1);
        return mk(3'd1, 0, 0, 0, 0, 0, 0, 5'd10, 2'd0, 0, 0);
      end
      PH_E: begin
        if (op == 5'd7) return mk(3'd2, z, 1, 0, 0, 0, 0, 5'd10, 2'd0, 0, 0);
        return mk(3'd2, 0, 0, 0, 0, 0, 0, 5'd10, lo, 0, 0);
      end
      PH_M: begin
        if (op == 5'd4) return mk(3'd3, 0, 0, 0, 1, 0, 0, 5'd10, 2'd0, 0, 0);
        return mk(3'd3, 0, 0, 0, 0, 1, 0, 5'd10, 2'd0, 0, 0);
      end
      PH_W: begin
        sel = (op == 5'd4) ? 5'd1 : (op == 5'd5) ? 5'd2 : 5'd0;
        return mk(3'd4, 0, 0, 0, 0, 0, 1, sel, (op <= 5'd3) ? lo : 2'd0, 0, 0);
      end
      default: return mk(3'd5, 0, 0, 0, 0, 0, 0, 5'd10, 2'd0, 1, 0);
    endcase
  endfunction

  // driver: one clock cycle of stimulus plus its expected response
  task automatic drive(input logic rst, input logic mr, input logic z,
                       input logic [4:0] op, input logic [17:0] e);
    @(posedge CLK);
    #1;
    Reset = rst;
    MemReady = mr;
    Zero = z;
    Opcode = op;
    exp_q.push_back(e);
  endtask

  // One instruction. zmode: 0/1 forces Zero in BEQZ EXEC, 2 = random.
  // abort_mem raises Reset on the first MEM cycle.
  task automatic issue(input logic [4:0] op, input int zmode, input bit abort_mem);
    int ph[$];
    int lows;
    logic z, mr;
    ph.push_back(PH_F);
    ph.push_back(PH_D);
    if (op <= 5'd3) begin ph.push_back(PH_E); ph.push_back(PH_W); end
    else if (op == 5'd4) begin ph.push_back(PH_M); ph.push_back(PH_W); end
    else if (op == 5'd5) ph.push_back(PH_W);
    else if (op == 5'd6) ph.push_back(PH_M);
    else if (op == 5'd7) ph.push_back(PH_E);
    else if (op == 5'd31) repeat (5) ph.push_back(PH_H);
    foreach (ph[i]) begin
      if (ph[i] == PH_M && abort_mem) begin
        drive(1'b1, 1'b1, 1'($urandom_range(0, 1)), op, rst_vec());
        return;
      end
      lows = 0;
      if (STALL && (ph[i] == PH_F || ph[i] == PH_M)) lows = $urandom_range(0, 3);
      for (int k = 0; k <= lows; k++) begin
        mr = (k == lows);
        z = 1'($urandom_range(0, 1));
        if (ph[i] == PH_E && op == 5'd7 && zmode < 2) z = (zmode == 1);
        drive(1'b0, mr, z, op, phase_exp(ph[i], op, z, mr));
      end
    end
    if (op == 5'd31) drive(1'b1, 1'b1, 1'b0, op, rst_vec());
  endtask

  // scoreboard monitor: compare every presented cycle away from the edge
  always @(negedge CLK) begin : monitor
    logic [17:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (act_vec !== e) begin
        n_bad++;
        $display("FAIL outputs t=%0t op=%0d got %b required %b", $time, Opcode, act_vec, e);
      end
    end
  end

  initial begin
    int r;
    logic [4:0] op;
    repeat (3) drive(1'b1, 1'b1, 1'b0, 5'd0, rst_vec());
    issue(5'd0, 2, 1'b0);
    issue(5'd4, 2, 1'b0);
    issue(5'd7, 1, 1'b0);
    issue(5'd7, 0, 1'b0);
    issue(5'd12, 2, 1'b0);
    issue(5'd6, 2, 1'b1);
    issue(5'd31, 2, 1'b0);
    issue(5'd5, 2, 1'b0);
    issue(5'd8, 2, 1'b0);
    repeat (60) begin
      r = $urandom_range(0, 11);
      if (r <= 8) op = 5'(r);
      else if (r <= 10) op = 5'($urandom_range(9, 30));
      else op = 5'd31;
      issue(op, 2, ($urandom_range(0, 5) == 0));
    end
    @(negedge CLK);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
